dft_bin_sequencer: RTL and testbench

Control block for the shared DFT complex multiplier. For each requested frequency bin k it sweeps n = 0..N_POINTS-1 and issues a sample address n and a twiddle address (k·n) mod N_POINTS to the sample RAM and twiddle ROM. Their read data feeds the existing `dft_complex_mul` directly. The block accumulates the returned products into one complex sum per bin and hands finished bins downstream through a 2-entry valid/ready output buffer.

---
 rtl/dft_bin_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_dft_bin_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dft_bin_sequencer.sv
// ---------------------------------------------------------------------------
// dft_bin_sequencer
//
// Sequences the shared DFT complex multiplier. For every requested bin k it
// sweeps n = 0..N_POINTS-1 and presents sample address n and twiddle address
// (k*n) mod N_POINTS. The returned products are summed into one complex
// value per bin. Finished bins leave through a 2-entry valid/ready buffer.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle request, honoured only when idle
//   k_first, k_count    first bin index and number of bins (0..N_POINTS)
//   busy, done          run in progress / one-cycle completion pulse
//   rd_en               memory read strobe, one per product
//   smp_addr, tw_addr   sample address n, twiddle address (k*n) mod N
//   mul_re, mul_im      signed multiplier result
//   bin_valid/ready     output handshake
//   bin_k, bin_re/im    bin index and signed sums of the head entry
// ---------------------------------------------------------------------------
module dft_bin_sequencer #(
    parameter int N_POINTS = 64,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 1,
    parameter int MUL_LAT  = 5,
    parameter int LOG2N    = $clog2(N_POINTS),
    parameter int ACC_W    = DATA_W + LOG2N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LOG2N-1:0]  k_first,
    input  logic [LOG2N:0]    k_count,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [LOG2N-1:0]  smp_addr,
    output logic [LOG2N-1:0]  tw_addr,
    input  logic [DATA_W-1:0] mul_re,
    input  logic [DATA_W-1:0] mul_im,
    output logic              bin_valid,
    input  logic              bin_ready,
    output logic [LOG2N-1:0]  bin_k,
    output logic [ACC_W-1:0]  bin_re,
    output logic [ACC_W-1:0]  bin_im
);

    // Stage 0 of the tag pipe is the rd_en/address register itself, so the
    // pipe has PIPE_D-1 further stages and its last stage lines up with mul_*.
    localparam int               PIPE_D = RD_LAT + MUL_LAT;
    localparam logic [LOG2N-1:0] N_LAST = LOG2N'(N_POINTS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    state_t             state_r, state_next_s;
    logic [LOG2N-1:0]   n_r, n_next_s, tw_r, tw_next_s, k_r, k_next_s;
    logic [LOG2N:0]     bins_left_r, bins_left_next_s;
    logic [1:0]         credits_r, credits_next_s;
    logic               rd_en_r, rd_en_next_s, busy_r, busy_next_s, done_r, done_next_s;
    logic               issue_s, first_s, last_s, ret_s, drain_ok_s;
    logic [PIPE_D-1:1]  tag_v_r, tag_f_r, tag_l_r;
    logic [LOG2N-1:0]   tag_k_r [1:PIPE_D-1];
    logic [ACC_W-1:0]   acc_re_r, acc_im_r, sum_re_s, sum_im_s;
    logic               push_s;
    logic [1:0]         vld_r, vld_next_s;
    logic [LOG2N-1:0]   hd_k_r, hd_k_next_s, tl_k_r, tl_k_next_s;
    logic [ACC_W-1:0]   hd_re_r, hd_re_next_s, hd_im_r, hd_im_next_s;
    logic [ACC_W-1:0]   tl_re_r, tl_re_next_s, tl_im_r, tl_im_next_s;

    assign issue_s    = (state_r == ST_ISSUE);
    assign first_s    = issue_s && (n_r == {LOG2N{1'b0}});
    assign last_s     = issue_s && (n_r == N_LAST);
    assign ret_s      = vld_r[0] && bin_ready;
    assign drain_ok_s = !(|tag_v_r) && (vld_r == 2'b00);
    assign push_s     = tag_v_r[PIPE_D-1] && tag_l_r[PIPE_D-1];

    // Credit bookkeeping: take on the n = 0 product, give back on each pop.
    always_comb begin
        credits_next_s = credits_r;
        if (first_s && !ret_s) begin
            credits_next_s = credits_r - 2'd1;
        end else if (ret_s && !first_s) begin
            credits_next_s = credits_r + 2'd1;
        end else begin
            credits_next_s = credits_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && (k_count != {(LOG2N+1){1'b0}})) begin
                    state_next_s = ST_ISSUE;
                end else if (start) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (last_s && (bins_left_r == (LOG2N+1)'(1))) begin
                    state_next_s = ST_DRAIN;
                end else if (last_s && (credits_next_s == 2'd0)) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (credits_r != 2'd0) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (drain_ok_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered strobes and counters.
    always_comb begin
        rd_en_next_s     = (state_next_s == ST_ISSUE);
        busy_next_s      = (state_next_s != ST_IDLE);
        done_next_s      = (state_r == ST_DONE);
        n_next_s         = n_r;
        tw_next_s        = tw_r;
        k_next_s         = k_r;
        bins_left_next_s = bins_left_r;
        if ((state_r == ST_IDLE) && start && (k_count != {(LOG2N+1){1'b0}})) begin
            n_next_s         = {LOG2N{1'b0}};
            tw_next_s        = {LOG2N{1'b0}};
            k_next_s         = k_first;
            bins_left_next_s = k_count;
        end else if (last_s) begin
            // Bin finished: restart the sweep for the next bin (k wraps).
            n_next_s         = {LOG2N{1'b0}};
            tw_next_s        = {LOG2N{1'b0}};
            k_next_s         = k_r + LOG2N'(1);
            bins_left_next_s = bins_left_r - (LOG2N+1)'(1);
        end else if (issue_s) begin
            n_next_s         = n_r + LOG2N'(1);
            tw_next_s        = tw_r + k_r;
        end else begin
            n_next_s         = n_r;
        end
    end

    // Control registers: strobes, sweep counters and credits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_en_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            n_r         <= {LOG2N{1'b0}};
            tw_r        <= {LOG2N{1'b0}};
            k_r         <= {LOG2N{1'b0}};
            bins_left_r <= {(LOG2N+1){1'b0}};
            credits_r   <= 2'd2;
        end else begin
            rd_en_r     <= rd_en_next_s;
            busy_r      <= busy_next_s;
            done_r      <= done_next_s;
            n_r         <= n_next_s;
            tw_r        <= tw_next_s;
            k_r         <= k_next_s;
            bins_left_r <= bins_left_next_s;
            credits_r   <= credits_next_s;
        end
    end

    // Accumulator input: the first product of a bin overwrites the sum.
    always_comb begin
        if (tag_f_r[PIPE_D-1]) begin
            sum_re_s = sext(mul_re);
            sum_im_s = sext(mul_im);
        end else begin
            sum_re_s = acc_re_r + sext(mul_re);
            sum_im_s = acc_im_r + sext(mul_im);
        end
    end

    // Tag pipe tracking products through memory and multiplier, plus the accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_v_r  <= {(PIPE_D-1){1'b0}};
            tag_f_r  <= {(PIPE_D-1){1'b0}};
            tag_l_r  <= {(PIPE_D-1){1'b0}};
            for (int i = 1; i < PIPE_D; i++) begin
                tag_k_r[i] <= {LOG2N{1'b0}};
            end
            acc_re_r <= {ACC_W{1'b0}};
            acc_im_r <= {ACC_W{1'b0}};
        end else begin
            tag_v_r[1] <= issue_s;
            tag_f_r[1] <= first_s;
            tag_l_r[1] <= last_s;
            tag_k_r[1] <= k_r;
            for (int i = 2; i < PIPE_D; i++) begin
                tag_v_r[i] <= tag_v_r[i-1];
                tag_f_r[i] <= tag_f_r[i-1];
                tag_l_r[i] <= tag_l_r[i-1];
                tag_k_r[i] <= tag_k_r[i-1];
            end
            if (tag_v_r[PIPE_D-1]) begin
                acc_re_r <= sum_re_s;
                acc_im_r <= sum_im_s;
            end else begin
                acc_re_r <= acc_re_r;
                acc_im_r <= acc_im_r;
            end
        end
    end

    // Output buffer next state; credits guarantee no push into a full buffer.
    always_comb begin
        vld_next_s   = vld_r;
        hd_k_next_s  = hd_k_r;
        hd_re_next_s = hd_re_r;
        hd_im_next_s = hd_im_r;
        tl_k_next_s  = tl_k_r;
        tl_re_next_s = tl_re_r;
        tl_im_next_s = tl_im_r;
        if (ret_s && vld_r[1]) begin
            hd_k_next_s  = tl_k_r;
            hd_re_next_s = tl_re_r;
            hd_im_next_s = tl_im_r;
            if (push_s) begin
                tl_k_next_s  = tag_k_r[PIPE_D-1];
                tl_re_next_s = sum_re_s;
                tl_im_next_s = sum_im_s;
                vld_next_s   = 2'b11;
            end else begin
                vld_next_s   = 2'b01;
            end
        end else if (push_s && (ret_s || !vld_r[0])) begin
            // Empty, or head leaving this cycle with no tail: new entry becomes head.
            hd_k_next_s  = tag_k_r[PIPE_D-1];
            hd_re_next_s = sum_re_s;
            hd_im_next_s = sum_im_s;
            vld_next_s   = 2'b01;
        end else if (push_s) begin
            tl_k_next_s  = tag_k_r[PIPE_D-1];
            tl_re_next_s = sum_re_s;
            tl_im_next_s = sum_im_s;
            vld_next_s   = 2'b11;
        end else if (ret_s) begin
            vld_next_s   = 2'b00;
        end else begin
            vld_next_s   = vld_r;
        end
    end

    // Output buffer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_r   <= 2'b00;
            hd_k_r  <= {LOG2N{1'b0}};
            hd_re_r <= {ACC_W{1'b0}};
            hd_im_r <= {ACC_W{1'b0}};
            tl_k_r  <= {LOG2N{1'b0}};
            tl_re_r <= {ACC_W{1'b0}};
            tl_im_r <= {ACC_W{1'b0}};
        end else begin
            vld_r   <= vld_next_s;
            hd_k_r  <= hd_k_next_s;
            hd_re_r <= hd_re_next_s;
            hd_im_r <= hd_im_next_s;
            tl_k_r  <= tl_k_next_s;
            tl_re_r <= tl_re_next_s;
            tl_im_r <= tl_im_next_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign rd_en     = rd_en_r;
    assign smp_addr  = n_r;
    assign tw_addr   = tw_r;
    assign bin_valid = vld_r[0];
    assign bin_k     = hd_k_r;
    assign bin_re    = hd_re_r;
    assign bin_im    = hd_im_r;

endmodule

// File: tb/tb_dft_bin_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dft_bin_sequencer
//
// Directed bench for dft_bin_sequencer at N_POINTS = 8. A small model of the
// sample RAM, twiddle ROM and Q15 complex multiplier returns each product
// five cycles after its rd_en cycle.
// ---------------------------------------------------------------------------
module tb_dft_bin_sequencer;

    logic              tb_clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [2:0]        k_first;
    logic [3:0]        k_count;
    logic              busy, done, rd_en;
    logic [2:0]        smp_addr, tw_addr;
    logic [15:0]       mul_re, mul_im;
    logic              bin_valid;
    logic              bin_ready;
    logic [2:0]        bin_k;
    logic [18:0]       bin_re, bin_im;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int got;
    int rd_cnt;
    int seen;
    logic [2:0]        got_k  [0:7];
    logic signed [18:0] got_re [0:7];
    logic signed [18:0] got_im [0:7];
    int tw_exp [0:7] = '{0, 3, 6, 1, 4, 7, 2, 5};
    int wrap_k [0:3] = '{6, 7, 0, 1};

    logic signed [15:0] smp_re_m [0:7];
    logic signed [15:0] smp_im_m [0:7];
    logic signed [15:0] tw_re_m  [0:7];
    logic signed [15:0] tw_im_m  [0:7];
    logic signed [15:0] dl_re [0:4];
    logic signed [15:0] dl_im [0:4];

    always #5 tb_clk = ~tb_clk;

    dft_bin_sequencer #(
        .N_POINTS(8), .DATA_W(16), .RD_LAT(1), .MUL_LAT(5)
    ) dut (
        .clk(tb_clk), .rst_n(rst_n), .start(start), .k_first(k_first),
        .k_count(k_count), .busy(busy), .done(done), .rd_en(rd_en),
        .smp_addr(smp_addr), .tw_addr(tw_addr), .mul_re(mul_re),
        .mul_im(mul_im), .bin_valid(bin_valid), .bin_ready(bin_ready),
        .bin_k(bin_k), .bin_re(bin_re), .bin_im(bin_im)
    );

    function automatic logic signed [15:0] q15(input longint v);
        longint s;
        s = v >>> 15;
        return s[15:0];
    endfunction

    // Memory read plus multiplier: product of the rd_en cycle appears 5 cycles later.
    always @(posedge tb_clk) begin
        dl_re[0] <= q15(longint'(smp_re_m[smp_addr]) * tw_re_m[tw_addr]
                        - longint'(smp_im_m[smp_addr]) * tw_im_m[tw_addr]);
        dl_im[0] <= q15(longint'(smp_re_m[smp_addr]) * tw_im_m[tw_addr]
                        + longint'(smp_im_m[smp_addr]) * tw_re_m[tw_addr]);
        for (int i = 1; i < 5; i++) begin
            dl_re[i] <= dl_re[i-1];
            dl_im[i] <= dl_im[i-1];
        end
    end
    assign mul_re = dl_re[4];
    assign mul_im = dl_im[4];

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge tb_clk);
    endtask

    task automatic set_mem(input logic signed [15:0] si);
        for (int j = 0; j < 8; j++) begin
            smp_re_m[j] = 16'sh1000;
            smp_im_m[j] = si;
            tw_re_m[j]  = 16'sh7FFF;
            tw_im_m[j]  = 16'sh0000;
        end
    endtask

    // Ends at the negedge of the first rd_en cycle.
    task automatic pulse_start(input logic [2:0] kf, input logic [3:0] kc);
        start = 1'b1; k_first = kf; k_count = kc;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_valid"}, bin_valid, 0);
        chk({tag, "_smp"}, smp_addr, 0);
        chk({tag, "_tw"}, tw_addr, 0);
        chk({tag, "_k"}, bin_k, 0);
        chk({tag, "_re"}, bin_re, 0);
        chk({tag, "_im"}, bin_im, 0);
    endtask

    task automatic wait_done(input string tag, input int bound);
        for (int c = 0; c < bound && !done; c++) tick();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_low"}, busy, 0);
        tick();
    endtask

    // Records every handshake until done; optionally pokes start mid-run.
    task automatic collect(input string tag, input int bound, input bit poke);
        got = 0;
        for (int c = 0; c < bound && !done; c++) begin
            if (rd_en) rd_cnt++;
            if (bin_valid && bin_ready) begin
                if (got < 8) begin
                    got_k[got]  = bin_k;
                    got_re[got] = $signed(bin_re);
                    got_im[got] = $signed(bin_im);
                end
                got++;
            end
            if (poke && c == 20) begin
                start = 1'b1; k_first = 3'd5; k_count = 4'd3;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_low"}, busy, 0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; k_first = 3'd0; k_count = 4'd0; bin_ready = 1'b1;
        set_mem(16'sh0000);
        tick(); tick(); tick();
        chk_all_zero("rst");
        rst_n = 1'b1;
        tick();

        // Twiddle sweep: k = 3.
        pulse_start(3'd3, 4'd1);
        chk("sweep_busy", busy, 1);
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("sweep_rd%0d", i), rd_en, i < 8);
            if (i < 8) begin
                chk($sformatf("sweep_smp%0d", i), smp_addr, i);
                chk($sformatf("sweep_tw%0d", i), tw_addr, tw_exp[i]);
            end
            if (i == 13) chk("sweep_k", bin_k, 3);
            if (i < 13) tick();
        end
        wait_done("sweep", 30);

        // Accumulation: 8 x 0x0FFF = 32760, result at first rd_en + 13.
        pulse_start(3'd0, 4'd1);
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("acc_valid%0d", i), bin_valid, i == 13);
            if (i < 13) tick();
        end
        chk("acc_re", $signed(bin_re), 32760);
        chk("acc_im", $signed(bin_im), 0);
        chk("acc_k", bin_k, 0);
        wait_done("acc", 30);

        // Backpressure: only two bins issue while the buffer is not drained.
        set_mem(-16'sh1000);
        bin_ready = 1'b0;
        rd_cnt = 0;
        pulse_start(3'd0, 4'd4);
        for (int c = 0; c < 60; c++) begin
            if (rd_en) rd_cnt++;
            tick();
        end
        chk("bp_rd_stall", rd_cnt, 16);
        chk("bp_valid", bin_valid, 1);
        chk("bp_head_k", bin_k, 0);
        chk("bp_busy", busy, 1);
        bin_ready = 1'b1;
        collect("bp", 300, 1'b0);
        chk("bp_count", got, 4);
        chk("bp_rd_total", rd_cnt, 32);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("bp_k%0d", j), got_k[j], j);
            chk($sformatf("bp_re%0d", j), got_re[j], 32760);
            chk($sformatf("bp_im%0d", j), got_im[j], -32768);
        end

        // Bin index wrap, with a start poked while busy.
        rd_cnt = 0;
        pulse_start(3'd6, 4'd4);
        collect("wrap", 300, 1'b1);
        chk("wrap_count", got, 4);
        chk("wrap_rd_total", rd_cnt, 32);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("wrap_k%0d", j), got_k[j], wrap_k[j]);
            chk($sformatf("wrap_re%0d", j), got_re[j], 32760);
        end

        // k_count = 0: done two cycles after start, no reads.
        start = 1'b1; k_first = 3'd1; k_count = 4'd0;
        tick();
        start = 1'b0;
        chk("k0_done_s1", done, 0);
        chk("k0_busy_s1", busy, 1);
        chk("k0_rd_s1", rd_en, 0);
        tick();
        chk("k0_done_s2", done, 1);
        chk("k0_busy_s2", busy, 0);
        chk("k0_rd_s2", rd_en, 0);
        tick();
        chk("k0_done_s3", done, 0);

        // Reset in the middle of a four-bin run.
        pulse_start(3'd0, 4'd4);
        for (int c = 0; c < 10; c++) tick();
        rst_n = 1'b0;
        tick();
        chk_all_zero("midrst");
        tick(); tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bin_valid || done || rd_en) seen++;
            tick();
        end
        chk("midrst_quiet", seen, 0);
        rd_cnt = 0;
        pulse_start(3'd2, 4'd1);
        collect("post", 100, 1'b0);
        chk("post_count", got, 1);
        chk("post_k", got_k[0], 2);
        chk("post_re", got_re[0], 32760);
        chk("post_rd_total", rd_cnt, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
